// File: rtl/wb_pkg.sv
// wb_pkg: opcode, register and exception constants shared by the MEM/WB stage.
package wb_pkg;
  localparam logic [4:0] OP_RTYPE    = 5'b00000;
  localparam logic [4:0] OP_JAL      = 5'b00011;
  localparam logic [4:0] OP_ADDI     = 5'b00101;
  localparam logic [4:0] OP_LW       = 5'b01000;
  localparam logic [4:0] REG_RA      = 5'd31;
  localparam logic [4:0] REG_RSTATUS = 5'd30;
  localparam logic [1:0] EXC_NONE    = 2'd0;
endpackage

// File: rtl/wb_perf_counters.sv
// wb_perf_counters: three free-running 32-bit wrap counters with individual increment enables.
// Ports: clock, reset (async, active-high), inc_retired/inc_loads/inc_bubbles enables,
// perf_retired/perf_loads/perf_bubbles counts.
module wb_perf_counters (
  input  logic        clock,
  input  logic        reset,
  input  logic        inc_retired,
  input  logic        inc_loads,
  input  logic        inc_bubbles,
  output logic [31:0] perf_retired,
  output logic [31:0] perf_loads,
  output logic [31:0] perf_bubbles
);
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      perf_retired <= '0;
      perf_loads   <= '0;
      perf_bubbles <= '0;
    end else begin
      if (inc_retired) perf_retired <= perf_retired + 32'd1;
      if (inc_loads)   perf_loads   <= perf_loads + 32'd1;
      if (inc_bubbles) perf_bubbles <= perf_bubbles + 32'd1;
    end
endmodule

// File: rtl/mem_wb_stage.sv
// mem_wb_stage: MEM/WB pipeline latch, writeback decode, register-file write port and retire pulse.
// Ports: clock, reset (async, active-high), stall_in/flush_in latch control, mem_* MEM-stage results,
// wb_valid, rf_write_enable/rf_write_reg/rf_write_data writeback port, retire_pulse,
// perf_retired/perf_loads/perf_bubbles counters (live only with WB_PERF_CNT_EN defined, else 0).
module mem_wb_stage
  import wb_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              stall_in,
  input  logic              flush_in,
  input  logic              mem_valid,
  input  logic [31:0]       mem_instruction,
  input  logic [DATA_W-1:0] mem_alu_result,
  input  logic [DATA_W-1:0] mem_load_data,
  input  logic [DATA_W-1:0] mem_pc_plus1,
  input  logic [1:0]        mem_exc_code,
  output logic              wb_valid,
  output logic              rf_write_enable,
  output logic [REG_AW-1:0] rf_write_reg,
  output logic [DATA_W-1:0] rf_write_data,
  output logic              retire_pulse,
  output logic [31:0]       perf_retired,
  output logic [31:0]       perf_loads,
  output logic [31:0]       perf_bubbles
);
  // Only the opcode and rd fields matter to writeback, so only those are latched.
  logic [4:0]        op, rd;
  logic [1:0]        exc;
  logic [DATA_W-1:0] alu, ld, pc1;
  logic              retired;
  logic              unused_bits;
  logic              is_alu, is_jal, is_lw, exc_ovr, writes;
  assign unused_bits = ^mem_instruction[21:0];
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      wb_valid <= 1'b0;
      op       <= '0;
      rd       <= '0;
      exc      <= '0;
      alu      <= '0;
      ld       <= '0;
      pc1      <= '0;
      retired  <= 1'b0;
    end else if (flush_in) begin
      wb_valid <= 1'b0;
      op       <= '0;
      rd       <= '0;
      exc      <= '0;
      retired  <= 1'b0;
    end else if (stall_in) begin
      retired  <= retired | wb_valid;
    end else begin
      wb_valid <= mem_valid;
      op       <= mem_valid ? mem_instruction[31:27] : '0;
      rd       <= mem_valid ? mem_instruction[26:22] : '0;
      exc      <= mem_valid ? mem_exc_code : EXC_NONE;
      alu      <= mem_alu_result;
      ld       <= mem_load_data;
      pc1      <= mem_pc_plus1;
      retired  <= 1'b0;
    end
  assign is_alu  = (op == OP_RTYPE) || (op == OP_ADDI);
  assign is_jal  = op == OP_JAL;
  assign is_lw   = op == OP_LW;
  assign writes  = is_alu | is_jal | is_lw;
  // An arithmetic overflow is reported by writing its code into the status register.
  assign exc_ovr = is_alu && (exc != EXC_NONE);
  always_comb begin
    rf_write_reg  = exc_ovr ? REG_AW'(REG_RSTATUS) : is_jal ? REG_AW'(REG_RA) : REG_AW'(rd);
    rf_write_data = exc_ovr ? DATA_W'(exc) : is_jal ? pc1 : is_lw ? ld : alu;
  end
  assign rf_write_enable = wb_valid & writes & (rf_write_reg != '0);
  assign retire_pulse    = wb_valid & ~retired;
`ifdef WB_PERF_CNT_EN
  wb_perf_counters u_perf (
    .clock        (clock),
    .reset        (reset),
    .inc_retired  (retire_pulse),
    .inc_loads    (retire_pulse & is_lw),
    .inc_bubbles  (flush_in | (~stall_in & ~mem_valid)),
    .perf_retired (perf_retired),
    .perf_loads   (perf_loads),
    .perf_bubbles (perf_bubbles)
  );
`else
  assign perf_retired = '0;
  assign perf_loads   = '0;
  assign perf_bubbles = '0;
`endif
endmodule

// File: tb/tb_mem_wb_stage.sv
// tb_mem_wb_stage: directed self-checking bench with a behavioural writeback model.
module tb_mem_wb_stage;
`ifdef WB_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif
  logic        clock = 0, reset = 1, stall_in = 0, flush_in = 0, mem_valid = 0;
  logic [31:0] mem_instruction = 0, mem_alu_result = 0, mem_load_data = 0, mem_pc_plus1 = 0;
  logic [1:0]  mem_exc_code = 0;
  logic        wb_valid, rf_write_enable, retire_pulse;
  logic [4:0]  rf_write_reg;
  logic [31:0] rf_write_data, perf_retired, perf_loads, perf_bubbles;
  int checks = 0, errors = 0;

  mem_wb_stage dut (
    .clock(clock), .reset(reset), .stall_in(stall_in), .flush_in(flush_in),
    .mem_valid(mem_valid), .mem_instruction(mem_instruction), .mem_alu_result(mem_alu_result),
    .mem_load_data(mem_load_data), .mem_pc_plus1(mem_pc_plus1), .mem_exc_code(mem_exc_code),
    .wb_valid(wb_valid), .rf_write_enable(rf_write_enable), .rf_write_reg(rf_write_reg),
    .rf_write_data(rf_write_data), .retire_pulse(retire_pulse),
    .perf_retired(perf_retired), .perf_loads(perf_loads), .perf_bubbles(perf_bubbles)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  function automatic logic [31:0] mk(input logic [4:0] op, input logic [4:0] rd);
    return {op, rd, 22'h15A5A5};
  endfunction

  // Model: the instruction as the spec describes it, plus how many edges it has sat stalled.
  logic        m_v;
  logic [31:0] m_i, m_alu, m_ld, m_pc, m_pr, m_pl, m_pb;
  logic [1:0]  m_exc;
  int          m_age;
  always @(posedge clock or posedge reset)
    if (reset) begin
      m_v <= 0; m_i <= 0; m_alu <= 0; m_ld <= 0; m_pc <= 0; m_exc <= 0; m_age <= 0;
      m_pr <= 0; m_pl <= 0; m_pb <= 0;
    end else begin
      if (m_v && m_age == 0) begin
        m_pr <= m_pr + 1;
        if (m_i[31:27] == 5'b01000) m_pl <= m_pl + 1;
      end
      if (flush_in) begin
        m_v <= 0; m_i <= 0; m_exc <= 0; m_age <= 0; m_pb <= m_pb + 1;
      end else if (stall_in) begin
        m_age <= m_age + 1;
      end else begin
        m_v <= mem_valid;
        m_i <= mem_valid ? mem_instruction : 0;
        m_exc <= mem_valid ? mem_exc_code : 0;
        m_alu <= mem_alu_result; m_ld <= mem_load_data; m_pc <= mem_pc_plus1;
        m_age <= 0;
        if (!mem_valid) m_pb <= m_pb + 1;
      end
    end

  always @(negedge clock) begin
    logic        wr;
    logic [4:0]  er;
    logic [31:0] ed;
    wr = 1; er = m_i[26:22]; ed = 0;
    case (m_i[31:27])
      5'b00000, 5'b00101: if (m_exc != 0) begin er = 30; ed = {30'd0, m_exc}; end else ed = m_alu;
      5'b00011: begin er = 31; ed = m_pc; end
      5'b01000: ed = m_ld;
      default: wr = 0;
    endcase
    chk("wb_valid", {31'd0, wb_valid}, {31'd0, m_v});
    chk("retire_pulse", {31'd0, retire_pulse}, {31'd0, m_v && m_age == 0});
    chk("rf_write_enable", {31'd0, rf_write_enable}, {31'd0, m_v && wr && er != 0});
    if (wr) begin
      chk("rf_write_reg", {27'd0, rf_write_reg}, {27'd0, er});
      chk("rf_write_data", rf_write_data, ed);
    end
    chk("perf_retired", perf_retired, PERF ? m_pr : 0);
    chk("perf_loads", perf_loads, PERF ? m_pl : 0);
    chk("perf_bubbles", perf_bubbles, PERF ? m_pb : 0);
  end

  task automatic step(input logic v, input logic [31:0] ins, input logic [31:0] alu,
                      input logic [31:0] ld, input logic [31:0] pc, input logic [1:0] exc,
                      input logic st, input logic fl);
    mem_valid = v; mem_instruction = ins; mem_alu_result = alu; mem_load_data = ld;
    mem_pc_plus1 = pc; mem_exc_code = exc; stall_in = st; flush_in = fl;
    @(posedge clock); #1;
  endtask

  initial begin
    repeat (2) @(posedge clock);
    #1;
    chk("reset wb_valid", {31'd0, wb_valid}, 0);
    chk("reset rf_write_data", rf_write_data, 0);
    reset = 0;
    step(1, mk(5'b01000, 5), 32'h11, 32'hDEADBEEF, 32'h4, 0, 0, 0);
    chk("lw en", {31'd0, rf_write_enable}, 1);
    chk("lw reg", {27'd0, rf_write_reg}, 5);
    chk("lw data", rf_write_data, 32'hDEADBEEF);
    chk("lw retire", {31'd0, retire_pulse}, 1);
    step(1, mk(5'b00011, 9), 32'h22, 32'h0, 32'h40, 0, 0, 0);
    chk("lw perf_loads", perf_loads, PERF ? 1 : 0);
    chk("jal reg", {27'd0, rf_write_reg}, 31);
    chk("jal data", rf_write_data, 32'h40);
    chk("jal en", {31'd0, rf_write_enable}, 1);
    step(1, mk(5'b00000, 0), 32'h123, 32'h0, 32'h41, 0, 0, 0);
    chk("r0 en", {31'd0, rf_write_enable}, 0);
    chk("r0 retire", {31'd0, retire_pulse}, 1);
    step(1, mk(5'b00000, 7), 32'h7FFF, 32'h0, 32'h42, 3, 0, 0);
    chk("exc reg", {27'd0, rf_write_reg}, 30);
    chk("exc data", rf_write_data, 3);
    chk("exc en", {31'd0, rf_write_enable}, 1);
    step(1, mk(5'b00101, 9), 32'h55, 32'h0, 32'h43, 0, 0, 0);
    step(1, mk(5'b00101, 12), 32'h66, 32'h0, 32'h44, 1, 0, 0);
    step(1, mk(5'b00111, 3), 32'h77, 32'h0, 32'h45, 0, 0, 0);
    chk("sw en", {31'd0, rf_write_enable}, 0);
    step(1, mk(5'b01000, 4), 32'h0, 32'h00000077, 32'h46, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      step(1, mk(5'b00000, 8), 32'h99, 32'h0, 32'h47, 0, 1, 0);
      chk("stall retire", {31'd0, retire_pulse}, 0);
      chk("stall en", {31'd0, rf_write_enable}, 1);
      chk("stall reg", {27'd0, rf_write_reg}, 4);
    end
    step(1, mk(5'b00000, 8), 32'h99, 32'h0, 32'h47, 0, 1, 1);
    chk("flush wb_valid", {31'd0, wb_valid}, 0);
    step(0, mk(5'b00000, 6), 32'hAA, 32'h0, 32'h48, 0, 0, 0);
    chk("bubble en", {31'd0, rf_write_enable}, 0);
    chk("bubble retire", {31'd0, retire_pulse}, 0);
    step(1, mk(5'b00000, 6), 32'hBB, 32'h0, 32'h49, 2, 0, 0);
    step(1, mk(5'b00101, 6), 32'hCC, 32'h0, 32'h4A, 0, 0, 1);
    step(0, 32'h0, 32'h0, 32'h0, 32'h0, 0, 1, 0);
    step(1, mk(5'b01000, 5), 32'h0, 32'h12345678, 32'h4B, 0, 0, 0);
    reset = 1;
    #1;
    chk("rst wb_valid", {31'd0, wb_valid}, 0);
    chk("rst en", {31'd0, rf_write_enable}, 0);
    chk("rst retire", {31'd0, retire_pulse}, 0);
    chk("rst reg", {27'd0, rf_write_reg}, 0);
    chk("rst perf_retired", perf_retired, 0);
    chk("rst perf_loads", perf_loads, 0);
    chk("rst perf_bubbles", perf_bubbles, 0);
    @(posedge clock); #1;
    reset = 0;
    step(1, mk(5'b00011, 2), 32'h0, 32'h0, 32'hFFFFFFFF, 0, 0, 0);
    step(1, mk(5'b00000, 13), 32'h31, 32'h0, 32'h0, 0, 0, 0);
    step(0, 32'h0, 32'h0, 32'h0, 32'h0, 0, 0, 0);
    @(posedge clock); #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
